// File: rtl/sram_a_image_loader_if.sv
// Pixel-stream handshake plus the shared SRAM_a write bus (nine per-bank enables).
// The master modport is the loader side; the slave modport is the pixel source and SRAM side.
interface sram_a_image_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  pix_valid;
  logic [7:0]            pix_data;
  logic                  pix_ready;
  logic                  sram_write_enable_a0;
  logic                  sram_write_enable_a1;
  logic                  sram_write_enable_a2;
  logic                  sram_write_enable_a3;
  logic                  sram_write_enable_a4;
  logic                  sram_write_enable_a5;
  logic                  sram_write_enable_a6;
  logic                  sram_write_enable_a7;
  logic                  sram_write_enable_a8;
  logic [3:0]            sram_bytemask_a;
  logic [ADDR_WIDTH-1:0] sram_waddr_a;
  logic [7:0]            sram_wdata_a;

  modport master (
    input  pix_valid, pix_data,
    output pix_ready,
    output sram_write_enable_a0, sram_write_enable_a1, sram_write_enable_a2,
    output sram_write_enable_a3, sram_write_enable_a4, sram_write_enable_a5,
    output sram_write_enable_a6, sram_write_enable_a7, sram_write_enable_a8,
    output sram_bytemask_a, sram_waddr_a, sram_wdata_a
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_ready,
    input  sram_write_enable_a0, sram_write_enable_a1, sram_write_enable_a2,
    input  sram_write_enable_a3, sram_write_enable_a4, sram_write_enable_a5,
    input  sram_write_enable_a6, sram_write_enable_a7, sram_write_enable_a8,
    input  sram_bytemask_a, sram_waddr_a, sram_wdata_a
  );
endinterface

// File: rtl/sram_a_image_loader.sv
// Scatters a raster-order pixel stream into the nine SRAM_a banks as 2x2 blocks packed in 32-bit words.
// Bank/address/lane come from incremental row/col and mod-3 counters; no dividers.
module sram_a_image_loader #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BANK_COLS  = 6
) (
  input  logic clk,
  input  logic srst,
  input  logic load_start,
  input  logic fc_done,
  output logic conv_start,
  output logic busy,
  sram_a_image_loader_if.master bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  state_t                state;
  logic [RW-1:0]         r;
  logic [CW-1:0]         c;
  logic [1:0]            br_m3, bc_m3;
  logic [ADDR_WIDTH-1:0] bc_d3, row_base;
  logic                  pix_ready_q;
  logic [8:0]            we_n;
  logic [3:0]            mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            data_q;

  logic       hs, last_col, last_row;
  logic [3:0] bank;
  logic [1:0] lane;

  assign hs       = bus.pix_valid & pix_ready_q;
  assign last_col = (c == C_LAST);
  assign last_row = (r == R_LAST);
  assign bank     = {2'b00, br_m3} * 4'd3 + {2'b00, bc_m3};
  assign lane     = {r[0], c[0]};

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      r           <= '0;
      c           <= '0;
      br_m3       <= '0;
      bc_m3       <= '0;
      bc_d3       <= '0;
      row_base    <= '0;
      pix_ready_q <= 1'b0;
      we_n        <= '1;
      mask_q      <= 4'hF;
      addr_q      <= '0;
      data_q      <= '0;
      conv_start  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      we_n       <= '1;
      mask_q     <= 4'hF;
      addr_q     <= '0;
      data_q     <= '0;
      conv_start <= 1'b0;

      if (hs) begin
        we_n   <= ~(9'd1 << bank);
        mask_q <= ~(4'd1 << lane);
        addr_q <= row_base + bc_d3;
        data_q <= bus.pix_data;
        if (last_col) begin
          c     <= '0;
          bc_m3 <= '0;
          bc_d3 <= '0;
          r     <= r + 1'b1;
          // Leaving an odd row crosses into the next block row.
          if (r[0]) begin
            if (br_m3 == 2'd2) begin
              br_m3    <= '0;
              row_base <= row_base + ADDR_WIDTH'(BANK_COLS);
            end else begin
              br_m3 <= br_m3 + 2'd1;
            end
          end
        end else begin
          c <= c + 1'b1;
          if (c[0]) begin
            if (bc_m3 == 2'd2) begin
              bc_m3 <= '0;
              bc_d3 <= bc_d3 + 1'b1;
            end else begin
              bc_m3 <= bc_m3 + 2'd1;
            end
          end
        end
      end

      case (state)
        IDLE: if (load_start) begin
          r           <= '0;
          c           <= '0;
          br_m3       <= '0;
          bc_m3       <= '0;
          bc_d3       <= '0;
          row_base    <= '0;
          pix_ready_q <= 1'b1;
          busy        <= 1'b1;
          state       <= LOAD;
        end
        // pix_ready drops after the last beat; the following cycle (write strobe) moves on.
        LOAD: begin
          if (hs && last_col && last_row) begin
            pix_ready_q <= 1'b0;
          end else if (!pix_ready_q) begin
            conv_start <= 1'b1;
            state      <= START;
          end
        end
        START: state <= WAIT;
        WAIT: if (fc_done) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready            = pix_ready_q;
  assign bus.sram_write_enable_a0 = we_n[0];
  assign bus.sram_write_enable_a1 = we_n[1];
  assign bus.sram_write_enable_a2 = we_n[2];
  assign bus.sram_write_enable_a3 = we_n[3];
  assign bus.sram_write_enable_a4 = we_n[4];
  assign bus.sram_write_enable_a5 = we_n[5];
  assign bus.sram_write_enable_a6 = we_n[6];
  assign bus.sram_write_enable_a7 = we_n[7];
  assign bus.sram_write_enable_a8 = we_n[8];
  assign bus.sram_bytemask_a      = mask_q;
  assign bus.sram_waddr_a         = addr_q;
  assign bus.sram_wdata_a         = data_q;
endmodule

// File: tb/tb_sram_a_image_loader.sv
// Scoreboard bench for sram_a_image_loader: expected writes are queued at each handshake
// and popped by a negedge monitor that also rebuilds the SRAM_a image.
module tb_sram_a_image_loader;
  localparam int IMG_W = 32, IMG_H = 32, AW = 10, BCOLS = 6, NPIX = IMG_W * IMG_H;

  typedef struct {
    int         bank;
    int         addr;
    logic [3:0] mask;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0, srst = 1'b1, load_start = 1'b0, fc_done = 1'b0;
  logic conv_start, busy;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, hs_cyc = 0, conv_cnt = 0, conv_cyc = 0, wr_seq = 0;
  exp_t q[$];
  logic [31:0] mem [0:9*64-1];
  int          obs_bank [NPIX];
  int          obs_addr [NPIX];
  logic [3:0]  obs_mask [NPIX];
  logic [7:0]  obs_data [NPIX];

  sram_a_image_loader_if #(.ADDR_WIDTH(AW)) bus ();

  sram_a_image_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_WIDTH(AW), .BANK_COLS(BCOLS)) dut (
    .clk(clk), .srst(srst), .load_start(load_start), .fc_done(fc_done),
    .conv_start(conv_start), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [8:0] we_n = {bus.sram_write_enable_a8, bus.sram_write_enable_a7, bus.sram_write_enable_a6,
                     bus.sram_write_enable_a5, bus.sram_write_enable_a4, bus.sram_write_enable_a3,
                     bus.sram_write_enable_a2, bus.sram_write_enable_a1, bus.sram_write_enable_a0};

  function automatic exp_t make_exp(input int idx);
    exp_t e;
    int r, c, br, bc;
    logic [7:0] d;
    r = idx / IMG_W;  c = idx % IMG_W;
    br = r / 2;       bc = c / 2;
    d = idx[7:0];
    e.bank = (br % 3) * 3 + (bc % 3);
    e.addr = (br / 3) * BCOLS + bc / 3;
    e.mask = 4'hF & ~(4'd1 << ((r % 2) * 2 + (c % 2)));
    e.data = d;
    return e;
  endfunction

  // Monitor: every written beat must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    int nlow, b, a;
    exp_t e;
    nlow = 0; b = 0;
    for (int i = 0; i < 9; i++) if (!we_n[i]) begin nlow++; b = i; end
    if (conv_start) begin conv_cnt++; conv_cyc = cyc; end
    n_checks++;
    if (nlow != 0) begin
      a = int'(bus.sram_waddr_a);
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: bank %0d addr %0d mask %b, no write expected", b, a, bus.sram_bytemask_a);
      end else begin
        e = q.pop_front();
        if (nlow != 1 || b != e.bank || a != e.addr || bus.sram_bytemask_a !== e.mask || bus.sram_wdata_a !== e.data) begin
          n_fail++;
          $display("FAIL write_map: got %0d enables low, bank %0d addr %0d mask %b data %h; expected bank %0d addr %0d mask %b data %h",
                   nlow, b, a, bus.sram_bytemask_a, bus.sram_wdata_a, e.bank, e.addr, e.mask, e.data);
        end
      end
      if (wr_seq < NPIX) begin
        obs_bank[wr_seq] = b; obs_addr[wr_seq] = a;
        obs_mask[wr_seq] = bus.sram_bytemask_a; obs_data[wr_seq] = bus.sram_wdata_a;
      end
      wr_seq++;
      if (a < 64) for (int l = 0; l < 4; l++) if (!bus.sram_bytemask_a[l]) mem[b*64+a][8*l +: 8] = bus.sram_wdata_a;
    end else if (bus.sram_bytemask_a !== 4'hF || bus.sram_waddr_a !== '0 || bus.sram_wdata_a !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_bus: mask %b addr %0d data %h, required F/0/0", bus.sram_bytemask_a, bus.sram_waddr_a, bus.sram_wdata_a);
    end
  end

  task automatic run_load(input bit rnd, input int npix);
    int idx, guard;
    q.delete(); wr_seq = 0; conv_cnt = 0;
    for (int i = 0; i < 9*64; i++) mem[i] = 'x;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    idx = 0; guard = 0;
    while (idx < npix && guard < 20000) begin
      bus.pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = idx[7:0];
      @(negedge clk);
      if (bus.pix_valid && bus.pix_ready) begin
        q.push_back(make_exp(idx));
        hs_cyc = cyc;
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    n_checks++;
    if (idx != npix) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d beats, required %0d", idx, npix);
    end
  endtask

  task automatic wait_conv_and_check(input string name);
    for (int k = 0; k < 10 && conv_cnt == 0; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    n_checks++;
    if (conv_cnt != 1) begin n_fail++; $display("FAIL %s_conv_count: %0d pulses, required 1", name, conv_cnt); end
    n_checks++;
    if (conv_cyc != hs_cyc + 2) begin n_fail++; $display("FAIL %s_conv_latency: %0d cycles after last handshake, required 2", name, conv_cyc - hs_cyc); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_wait: busy %b, required 1", name, busy); end
    n_checks++;
    if (wr_seq != NPIX || q.size() != 0) begin n_fail++; $display("FAIL %s_write_count: %0d writes, %0d pending, required %0d/0", name, wr_seq, q.size(), NPIX); end
  endtask

  task automatic check_image(input string name);
    logic [31:0] ew [0:9*64-1];
    exp_t e;
    int lane, bad;
    for (int i = 0; i < 9*64; i++) ew[i] = 'x;
    for (int idx = 0; idx < NPIX; idx++) begin
      e = make_exp(idx);
      lane = ((idx / IMG_W) % 2) * 2 + (idx % 2);
      ew[e.bank*64+e.addr][8*lane +: 8] = e.data;
    end
    bad = 0;
    for (int b = 0; b < 9; b++)
      for (int a = 0; a < 36; a++) begin
        n_checks++;
        if (mem[b*64+a] !== ew[b*64+a]) begin
          n_fail++;
          if (bad < 5) $display("FAIL %s_image: bank %0d addr %0d holds %h, required %h", name, b, a, mem[b*64+a], ew[b*64+a]);
          bad++;
        end
      end
  endtask

  task automatic pulse_fc_done(input bit with_load);
    @(posedge clk); #1 fc_done = 1'b1; load_start = with_load;
    @(posedge clk); #1 fc_done = 1'b0; load_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fc_done_idle: busy %b, required 0", busy); end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.pix_ready !== 1'b0 || we_n !== 9'h1FF || bus.sram_bytemask_a !== 4'hF || bus.sram_waddr_a !== '0 ||
        bus.sram_wdata_a !== 8'h00 || conv_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready %b we %b mask %b addr %0d data %h conv %b busy %b, required 0/1ff/f/0/00/0/0",
               bus.pix_ready, we_n, bus.sram_bytemask_a, bus.sram_waddr_a, bus.sram_wdata_a, conv_start, busy);
    end
    #1 srst = 1'b0;
  endtask

  task automatic test_idle_valid();
    int bad;
    q.delete(); wr_seq = 0; bad = 0;
    @(posedge clk); #1 bus.pix_valid = 1'b1; bus.pix_data = 8'h5A;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.pix_ready !== 1'b0) bad++;
    end
    #1 bus.pix_valid = 1'b0;
    n_checks++;
    if (bad != 0 || wr_seq != 0) begin n_fail++; $display("FAIL idle_valid: %0d ready cycles, %0d writes, required 0/0", bad, wr_seq); end
  endtask

  task automatic test_back_to_back();
    run_load(1'b0, NPIX);
    wait_conv_and_check("b2b");
    check_image("b2b");
  endtask

  task automatic test_mapping();
    int mi [5] = '{0, 1, 33, 70, 1023};
    int eb [5] = '{0, 0, 0, 3, 0};
    int ea [5] = '{0, 0, 0, 1, 35};
    logic [3:0] em [5] = '{4'b1110, 4'b1101, 4'b0111, 4'b1110, 4'b0111};
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (obs_bank[mi[k]] != eb[k] || obs_addr[mi[k]] != ea[k] || obs_mask[mi[k]] !== em[k]) begin
        n_fail++;
        $display("FAIL map_pixel%0d: bank %0d addr %0d mask %b, required bank %0d addr %0d mask %b",
                 mi[k], obs_bank[mi[k]], obs_addr[mi[k]], obs_mask[mi[k]], eb[k], ea[k], em[k]);
      end
    end
  endtask

  task automatic test_wait_state();
    int bad;
    bad = 0;
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || bus.pix_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wait_load_ignored: %0d bad cycles, required 0", bad); end
    pulse_fc_done(1'b1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || bus.pix_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL wait_load_dropped: %0d busy/ready cycles, required 0", bad); end
  endtask

  task automatic test_random_valid();
    run_load(1'b1, NPIX);
    wait_conv_and_check("rnd");
    check_image("rnd");
    pulse_fc_done(1'b0);
  endtask

  task automatic test_abort();
    run_load(1'b0, 500);
    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    @(posedge clk); #1 srst = 1'b1;
    @(posedge clk); #1 srst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.pix_ready !== 1'b0 || we_n !== 9'h1FF || conv_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: ready %b we %b conv %b busy %b, required 0/1ff/0/0", bus.pix_ready, we_n, conv_start, busy);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (conv_cnt != 0 || wr_seq != 500) begin n_fail++; $display("FAIL abort_no_conv: %0d pulses %0d writes, required 0/500", conv_cnt, wr_seq); end
    run_load(1'b0, NPIX);
    wait_conv_and_check("reload");
    n_checks++;
    if (obs_bank[0] != 0 || obs_addr[0] != 0 || obs_mask[0] !== 4'b1110 || obs_data[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL reload_first: bank %0d addr %0d mask %b data %h, required 0/0/1110/00", obs_bank[0], obs_addr[0], obs_mask[0], obs_data[0]);
    end
    check_image("reload");
    pulse_fc_done(1'b0);
  endtask

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    test_reset();
    test_idle_valid();
    test_back_to_back();
    test_mapping();
    test_wait_state();
    test_random_valid();
    test_abort();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
